// File: rtl/segled_avmm_writer_pkg.sv
// segled_avmm_writer_pkg: segled register map, value limits and writer FSM states.
package segled_avmm_writer_pkg;
  localparam int VAL_W = 20;
  localparam int PT_W = 6;
  localparam logic [3:0] ADDR_DATA = 4'd0;
  localparam logic [3:0] ADDR_POINT = 4'd1;
  localparam logic [3:0] ADDR_SIGN = 4'd2;
  localparam logic [3:0] ADDR_EN = 4'd3;
  localparam logic [VAL_W-1:0] MAX_VAL = 20'd999999;
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_POINT, S_SIGN, S_EN} state_e;
  function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction
endpackage

// File: rtl/segled_avmm_writer.sv
// segled_avmm_writer: Avalon-MM master committing one display command as four segled register writes.
module segled_avmm_writer
  import segled_avmm_writer_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [VAL_W-1:0]  cmd_value,
  input  logic [PT_W-1:0]   cmd_point,
  input  logic              cmd_sign,
  input  logic              cmd_en,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              done,
  output logic              err_timeout,
  output logic              sat
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [VAL_W-1:0] val_q;
  logic [PT_W-1:0] point_q;
  logic sign_q, en_q, live_q;
  logic accept, stall, abort;
  // live_q keeps cmd_ready low for the cycle following any reset edge
  assign cmd_ready = live_q & (state_q == S_IDLE);
  assign accept = cmd_valid & cmd_ready;
  assign stall = avm_write & avm_waitrequest;
  assign abort = stall & (wcnt_q == CW'(TIMEOUT - 1));
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      wcnt_q <= '0;
      live_q <= 1'b0;
      done <= 1'b0;
      err_timeout <= 1'b0;
      sat <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      live_q <= 1'b1;
      done <= (state_q == S_EN) & ~avm_waitrequest;
      err_timeout <= abort;
      sat <= accept & (cmd_value > MAX_VAL);
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      val_q <= '0;
      point_q <= '0;
      sign_q <= 1'b0;
      en_q <= 1'b0;
    end else if (accept) begin
      val_q <= clamp_val(cmd_value);
      point_q <= cmd_point;
      sign_q <= cmd_sign;
      en_q <= cmd_en;
    end
  end
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) state_d = accept ? S_DATA : S_IDLE;
    else if (abort) state_d = S_IDLE;
    else if (!avm_waitrequest) state_d = (state_q == S_EN) ? S_IDLE : state_e'(state_q + 3'd1);
    wcnt_d = (state_d != state_q) ? '0 : stall ? wcnt_q + CW'(1) : wcnt_q;
  end
  always_comb begin
    avm_write = state_q != S_IDLE;
    avm_address = ADDR_W'(state_q == S_POINT ? ADDR_POINT :
                          state_q == S_SIGN  ? ADDR_SIGN  :
                          state_q == S_EN    ? ADDR_EN    : ADDR_DATA);
    avm_writedata = state_q == S_DATA  ? 32'(val_q)   :
                    state_q == S_POINT ? 32'(point_q) :
                    state_q == S_SIGN  ? 32'(sign_q)  :
                    state_q == S_EN    ? 32'(en_q)    : 32'd0;
  end
endmodule

// File: tb/tb_segled_avmm_writer.sv
// tb_segled_avmm_writer: directed checks of write sequence, clamping, stalls, timeout and reset.
module tb_segled_avmm_writer;
  logic sys_clk = 0, sys_rst = 1, cmd_valid = 0, cmd_ready;
  logic [19:0] cmd_value = 0;
  logic [5:0] cmd_point = 0;
  logic cmd_sign = 0, cmd_en = 0;
  logic [3:0] avm_address;
  logic avm_write, avm_waitrequest = 0;
  logic [31:0] avm_writedata;
  logic done, err_timeout, sat;
  int errs = 0, checks = 0, cyc = 0;
  int stall_left = 0;
  logic [3:0] stall_addr = 0;
  int wa[$], wd[$], wcyc[$], sa[$], sd[$], acc_cyc[$], done_cyc[$], err_cyc[$], sat_cyc[$];

  segled_avmm_writer #(.ADDR_W(4), .TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_value(cmd_value), .cmd_point(cmd_point), .cmd_sign(cmd_sign), .cmd_en(cmd_en),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .done(done), .err_timeout(err_timeout), .sat(sat)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (stall_left > 0 && avm_write && avm_address == stall_addr) begin
      avm_waitrequest = 1;
      stall_left--;
    end else avm_waitrequest = 0;
  end

  always @(posedge sys_clk) begin
    if (!sys_rst) begin
      if (avm_write && !avm_waitrequest) begin wa.push_back(avm_address); wd.push_back(avm_writedata); wcyc.push_back(cyc); end
      if (avm_write && avm_waitrequest) begin sa.push_back(avm_address); sd.push_back(avm_writedata); end
      if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      if (err_timeout) err_cyc.push_back(cyc);
      if (sat) sat_cyc.push_back(cyc);
    end
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear();
    wa.delete(); wd.delete(); wcyc.delete(); sa.delete(); sd.delete();
    acc_cyc.delete(); done_cyc.delete(); err_cyc.delete(); sat_cyc.delete();
  endtask

  task automatic send(input logic [19:0] v, input logic [5:0] p, input logic s, input logic e);
    int n;
    @(negedge sys_clk);
    n = acc_cyc.size();
    cmd_value = v; cmd_point = p; cmd_sign = s; cmd_en = e; cmd_valid = 1;
    for (int i = 0; i < 20 && acc_cyc.size() == n; i++) @(negedge sys_clk);
    cmd_valid = 0;
    if (acc_cyc.size() == n) chk("accept_bound", 0, 1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2000 && !cmd_ready; i++) @(negedge sys_clk);
    if (!cmd_ready) chk("idle_bound", 0, 1);
    @(negedge sys_clk);
  endtask

  task automatic exp_writes(input string tag, input int base, input int v, input int p, input int s, input int e);
    int ed[4];
    ed = '{v, p, s, e};
    if (wa.size() < base + 4) chk({tag, "_nwr"}, wa.size(), base + 4);
    else for (int i = 0; i < 4; i++) begin
      chk({tag, "_addr"}, wa[base+i], i);
      chk({tag, "_data"}, wd[base+i], ed[i]);
      chk({tag, "_cyc"}, wcyc[base+i] - wcyc[base], i);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_pulses", {done, err_timeout, sat}, 0);
    sys_rst = 0;
    @(negedge sys_clk);
    chk("ready_after_rst", cmd_ready, 1);

    // 1: plain sequence, no stalls
    clear();
    send(20'd123456, 6'b000100, 0, 1);
    wait_idle();
    exp_writes("t1", 0, 123456, 4, 0, 1);
    if (wcyc.size() == 4 && acc_cyc.size() == 1 && done_cyc.size() == 1) begin
      chk("t1_lat", wcyc[0] - acc_cyc[0], 1);
      chk("t1_done_cyc", done_cyc[0] - wcyc[3], 1);
    end else chk("t1_counts", {wcyc.size(), done_cyc.size()}, {32'd4, 32'd1});
    chk("t1_sat", sat_cyc.size(), 0);
    chk("t1_err", err_cyc.size(), 0);

    // 2: clamp at and around MAX_VAL
    clear();
    send(20'hFFFFF, 6'b101010, 1, 0);
    wait_idle();
    exp_writes("t2a", 0, 999999, 42, 1, 0);
    chk("t2a_sat_n", sat_cyc.size(), 1);
    if (sat_cyc.size() == 1 && acc_cyc.size() == 1) chk("t2a_sat_cyc", sat_cyc[0] - acc_cyc[0], 1);
    clear();
    send(20'd999999, 6'b000000, 0, 1);
    wait_idle();
    exp_writes("t2b", 0, 999999, 0, 0, 1);
    chk("t2b_sat_n", sat_cyc.size(), 0);
    clear();
    send(20'd1000000, 6'b111111, 0, 1);
    wait_idle();
    exp_writes("t2c", 0, 999999, 63, 0, 1);
    chk("t2c_sat_n", sat_cyc.size(), 1);

    // 3: three stall cycles on the POINT write
    clear();
    stall_addr = 1; stall_left = 3;
    send(20'd777, 6'b000100, 1, 1);
    wait_idle();
    chk("t3_nstall", sa.size(), 3);
    foreach (sa[i]) begin
      chk("t3_stall_addr", sa[i], 1);
      chk("t3_stall_data", sd[i], 4);
    end
    if (wa.size() == 4) begin
      chk("t3_gap", wcyc[1] - wcyc[0], 4);
      chk("t3_addr3", wa[3], 3);
      chk("t3_data3", wd[3], 1);
    end else chk("t3_nwr", wa.size(), 4);
    chk("t3_done", done_cyc.size(), 1);

    // 4: timeout on the SIGN write
    clear();
    stall_addr = 2; stall_left = 1000;
    send(20'd55, 6'b000011, 1, 1);
    wait_idle();
    stall_left = 0;
    chk("t4_nwr", wa.size(), 2);
    chk("t4_nstall", sa.size(), 8);
    chk("t4_err_n", err_cyc.size(), 1);
    chk("t4_done_n", done_cyc.size(), 0);
    if (err_cyc.size() == 1 && acc_cyc.size() == 1) chk("t4_err_cyc", err_cyc[0] - acc_cyc[0], 11);
    chk("t4_ready", cmd_ready, 1);
    chk("t4_write", avm_write, 0);

    // 5: reset during W_POINT
    clear();
    send(20'd31415, 6'b000001, 1, 1);
    for (int i = 0; i < 10 && !(avm_write && avm_address == 1); i++) @(negedge sys_clk);
    chk("t5_in_point", avm_address, 1);
    sys_rst = 1;
    @(negedge sys_clk);
    chk("t5_write", avm_write, 0);
    chk("t5_ready", cmd_ready, 0);
    chk("t5_addr", avm_address, 0);
    sys_rst = 0;
    @(negedge sys_clk);
    chk("t5_ready_back", cmd_ready, 1);
    clear();
    send(20'd2718, 6'b100000, 0, 1);
    wait_idle();
    exp_writes("t5", 0, 2718, 32, 0, 1);
    chk("t5_done", done_cyc.size(), 1);

    // 6: cmd_valid held high; fields change after the first accept
    clear();
    @(negedge sys_clk);
    cmd_value = 20'd654321; cmd_point = 6'b000001; cmd_sign = 1; cmd_en = 1; cmd_valid = 1;
    for (int i = 0; i < 20 && acc_cyc.size() == 0; i++) @(negedge sys_clk);
    cmd_value = 20'd42; cmd_point = 6'b110000; cmd_sign = 0; cmd_en = 1;
    for (int i = 0; i < 40 && acc_cyc.size() < 2; i++) begin
      @(negedge sys_clk);
      if (acc_cyc.size() < 2) cmd_point = cmd_point ^ 6'b000010;
    end
    cmd_valid = 0;
    cmd_point = 6'b110000;
    wait_idle();
    exp_writes("t6a", 0, 654321, 1, 1, 1);
    chk("t6_nacc", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2 && done_cyc.size() >= 1) chk("t6_acc_on_done", acc_cyc[1], done_cyc[0]);
    if (wa.size() >= 8) begin
      chk("t6b_data0", wd[4], 42);
      chk("t6b_addr3", wa[7], 3);
    end else chk("t6_nwr", wa.size(), 8);
    chk("t6_done_n", done_cyc.size(), 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
